// File: rtl/cam_seq_pkg.sv
// Shared types and frame geometry for the camera frame sequencer.
// Derived constants follow from the frame size and buffer word width.
package cam_seq_pkg;

  localparam int FRAME_BITS = 15440;
  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 9;
  localparam int BIT_CNT_W  = 15;

  localparam int WORDS_PER_FRAME = (FRAME_BITS + WORD_W - 1) / WORD_W;
  localparam int LAST_WORD_BITS  = FRAME_BITS % WORD_W;
  localparam int LAST_ADDR       = WORDS_PER_FRAME - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } cam_state_t;

endpackage

// File: rtl/cam_bit_packer.sv
// Serial-to-parallel packer: bits land LSB first; a full word, or the last
// bit of the frame, emits the word as a registered one-cycle pulse.
module cam_bit_packer
  import cam_seq_pkg::*;
(
  input  logic              hfclk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              bit_in,
  input  logic              last_bit,
  output logic              word_vld,
  output logic [WORD_W-1:0] word_data
);

  localparam int POS_W = $clog2(WORD_W);

  logic [WORD_W-1:0] sr_q, sr_d, sr_next;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              word_vld_q, word_vld_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_comb begin
    sr_d       = sr_q;
    pos_d      = pos_q;
    word_d     = word_q;
    word_vld_d = 1'b0;
    sr_next    = sr_q;
    sr_next[pos_q] = bit_in;
    if (clr) begin
      sr_d   = '0;
      pos_d  = '0;
      word_d = '0;
    end else if (shift_en) begin
      // The shift register restarts from zero, so a partial word is zero-filled.
      if (pos_q == POS_W'(WORD_W - 1) || last_bit) begin
        word_d     = sr_next;
        word_vld_d = 1'b1;
        sr_d       = '0;
        pos_d      = '0;
      end else begin
        sr_d  = sr_next;
        pos_d = pos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q       <= '0;
      pos_q      <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      pos_q      <= pos_d;
      word_q     <= word_d;
      word_vld_q <= word_vld_d;
    end
  end

  assign word_vld  = word_vld_q;
  assign word_data = word_q;

endmodule

// File: rtl/cam_frame_sequencer.sv
// Captures one serial camera frame into the word-wide frame buffer.
// Write port handshake: a write transfers on a cycle where wr_vld & wr_rdy are both high; wr_addr/wr_data hold while wr_vld & !wr_rdy.
module cam_frame_sequencer
  import cam_seq_pkg::*;
(
  input  logic                 hfclk,
  input  logic                 rst_n,
  input  logic                 cmd_start,
  input  logic                 cmd_abort,
  input  logic                 cam_bit_vld,
  input  logic                 cam_bit,
  output logic                 busy,
  output logic                 wr_vld,
  input  logic                 wr_rdy,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [WORD_W-1:0]    wr_data,
  output logic                 frame_done,
  output logic                 overrun,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output cam_state_t           dbg_state
);

  cam_state_t           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]    wr_data_q, wr_data_d;
  logic                 wr_vld_q, wr_vld_d;
  logic                 overrun_q, overrun_d;
  logic                 last_issued_q, last_issued_d;

  logic              start_act, abort_act, shift_en, last_bit, pk_clr;
  logic              pk_word_vld, hs, done_ok;
  logic [WORD_W-1:0] pk_word;

  assign start_act = (state_q == IDLE) && cmd_start && !cmd_abort;
  assign abort_act = cmd_abort && ((state_q == CAPTURE) || (state_q == FLUSH));
  assign shift_en  = (state_q == CAPTURE) && cam_bit_vld && !cmd_abort &&
                     (bit_cnt_q < BIT_CNT_W'(FRAME_BITS));
  assign last_bit  = (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1));
  assign pk_clr    = start_act || abort_act;
  assign hs        = wr_vld_q && wr_rdy;
  // The frame is finished once the last word has been issued and the output slot drains.
  assign done_ok   = last_issued_q && (!wr_vld_q || wr_rdy);

  cam_bit_packer u_packer (
    .hfclk     (hfclk),
    .rst_n     (rst_n),
    .clr       (pk_clr),
    .shift_en  (shift_en),
    .bit_in    (cam_bit),
    .last_bit  (last_bit),
    .word_vld  (pk_word_vld),
    .word_data (pk_word)
  );

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    idx_d         = idx_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_vld_d      = wr_vld_q;
    overrun_d     = overrun_q;
    last_issued_d = last_issued_q;

    case (state_q)
      IDLE: begin
        if (start_act) begin
          state_d       = CAPTURE;
          bit_cnt_d     = '0;
          idx_d         = '0;
          wr_addr_d     = '0;
          wr_data_d     = '0;
          overrun_d     = 1'b0;
          last_issued_d = 1'b0;
        end
      end
      CAPTURE: begin
        if (shift_en) bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS)) begin
          if (LAST_WORD_BITS != 0) state_d = FLUSH;
          else if (done_ok)        state_d = DONE;
        end
      end
      FLUSH: begin
        if (done_ok) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == CAPTURE) || (state_q == FLUSH)) begin
      if (hs) wr_vld_d = 1'b0;
      // The word index advances on completion even when the word is dropped.
      if (pk_word_vld) begin
        idx_d = idx_q + 1'b1;
        if (idx_q == ADDR_W'(LAST_ADDR)) last_issued_d = 1'b1;
        if (!wr_vld_q || wr_rdy) begin
          wr_vld_d  = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = pk_word;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end

    if (abort_act) begin
      state_d  = IDLE;
      wr_vld_d = 1'b0;
    end
  end

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      idx_q         <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_vld_q      <= 1'b0;
      overrun_q     <= 1'b0;
      last_issued_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      idx_q         <= idx_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_vld_q      <= wr_vld_d;
      overrun_q     <= overrun_d;
      last_issued_q <= last_issued_d;
    end
  end

  assign busy       = (state_q == CAPTURE) || (state_q == FLUSH);
  assign frame_done = (state_q == DONE);
  assign wr_vld     = wr_vld_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign overrun    = overrun_q;
  assign bit_cnt    = bit_cnt_q;
  assign dbg_state  = state_q;

endmodule
